// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the instruction/data memory port arbiter
// and other bus masters that reuse its timeout counter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2,
    DONE = 2'd3
  } arbState_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Bits needed to hold 0..limit without wrapping.
  function automatic int cntWidth(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// Saturating wait-cycle counter for a bus master; tc flags the cycle in
// which another un-acked cycle would bring the count up to LIMIT.
module bus_timeout_cnt
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = 255,
  parameter int CNT_W = cntWidth(LIMIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  // Terminal when this enabled cycle is the LIMIT-th one without an ack.
  assign tc = en && (count >= CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises the core's data and instruction accesses onto one req/ack bus,
// stalling the core until every access requested this core cycle is done.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_ren,
  input  logic [DATA_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_data,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] mem_din,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err
);

  arbState_t state, nextState;

  logic inAccess;
  logic ackSeen;
  logic timedOut;
  logic accessEnd;
  logic loadData;
  logic loadInst;
  logic anyReq;

  assign anyReq    = inst_ren || mem_ren || mem_wen;
  assign stall     = (state != DONE) && anyReq;

  // Acks outside DATA/INST (bus_req low) are ignored.
  assign inAccess  = (state == DATA) || (state == INST);
  assign ackSeen   = inAccess && bus_ack;
  assign accessEnd = ackSeen || timedOut;

  bus_timeout_cnt #(
    .LIMIT (TIMEOUT)
  ) uTimeout (
    .clk   (clk),
    .rst   (rst),
    .clear (loadData || loadInst),
    .en    (inAccess && !bus_ack),
    .tc    (timedOut)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Data first so the older pipeline instruction is served before the fetch.
  always_comb begin
    nextState = state;
    loadData  = 1'b0;
    loadInst  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_wen || mem_ren) begin
          nextState = DATA;
          loadData  = 1'b1;
        end else if (inst_ren) begin
          nextState = INST;
          loadInst  = 1'b1;
        end
      end
      DATA: begin
        if (accessEnd) begin
          if (inst_ren) begin
            nextState = INST;
            loadInst  = 1'b1;
          end else begin
            nextState = DONE;
          end
        end
      end
      INST: begin
        if (accessEnd) begin
          nextState = DONE;
        end
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // A following fetch reloads the bus registers on the same edge the data
  // access completes, so bus_req stays high across the back-to-back pair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_err   <= 1'b0;
      mem_din   <= '0;
      inst_data <= '0;
    end else begin
      if (loadData) begin
        bus_req  <= 1'b1;
        bus_we   <= mem_wen;
        bus_addr <= mem_addr;
        if (mem_wen) begin
          bus_wdata <= mem_dout;
        end
      end else if (loadInst) begin
        bus_req  <= 1'b1;
        bus_we   <= 1'b0;
        bus_addr <= inst_addr;
      end else if (accessEnd) begin
        bus_req <= 1'b0;
      end

      if (timedOut) begin
        bus_err <= 1'b1;
      end

      // A timed-out write is simply dropped; a timed-out read returns ERR_DATA.
      if ((state == DATA) && accessEnd && !bus_we) begin
        mem_din <= ackSeen ? bus_rdata : ERR_DATA;
      end

      if ((state == INST) && accessEnd) begin
        inst_data <= ackSeen ? bus_rdata : ERR_DATA;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter with a behavioural
// model of core transactions and a scripted variable-latency slave.
module tb_mem_port_arbiter;

  localparam int          TO   = 4;
  localparam logic [31:0] ERRV = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_ren = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_data;
  logic        mem_ren = 1'b0;
  logic        mem_wen = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_dout = '0;
  logic [31:0] mem_din;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic        bus_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .DATA_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inst_ren  (inst_ren),
    .inst_addr (inst_addr),
    .inst_data (inst_data),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .stall     (stall),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .bus_err   (bus_err)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    logic [31:0] mdin;
    logic [31:0] idata;
    bit          err;
    int          stallCyc;
  } res_t;

  typedef struct {
    int          w;
    logic [31:0] rdata;
  } plan_t;

  acc_t  expAcc[$];
  res_t  expRes[$];
  plan_t slvPlan[$];

  int total = 0;
  int bad   = 0;

  logic [31:0] mdinM  = '0;
  logic [31:0] idataM = '0;
  bit          errM   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Slave: each access follows the next plan entry; ack after w wait cycles,
  // never if w >= TO. Random spurious acks while bus_req is low.
  initial begin
    plan_t sp;
    bit    sActive;
    int    k;
    sActive = 0;
    k = 0;
    sp = '{w: 99, rdata: 32'h0};
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        sActive = 0;
        bus_ack = 1'b0;
      end else if (bus_req) begin
        if (!sActive) begin
          if (slvPlan.size() != 0) sp = slvPlan.pop_front();
          else sp = '{w: 99, rdata: 32'h0};
          sActive = 1;
          k = 0;
        end
        bus_ack   = (k == sp.w);
        bus_rdata = bus_ack ? sp.rdata : $urandom;
        k++;
        if (bus_ack || k == TO) sActive = 0;
      end else begin
        bus_ack   = ($urandom_range(0, 2) == 0);
        bus_rdata = $urandom;
      end
    end
  end

  // Monitor: bus accesses against expAcc, core-cycle completions against expRes.
  initial begin
    acc_t cur;
    res_t r;
    bit   inAcc;
    bit   haveCur;
    int   nReq;
    int   stallCnt;
    inAcc = 0;
    haveCur = 0;
    nReq = 0;
    stallCnt = 0;
    cur = '{we: 1'b0, addr: 32'h0, wdata: 32'h0};
    forever begin
      @(negedge clk);
      if (!rst) begin
        inAcc = 0;
        haveCur = 0;
        nReq = 0;
        stallCnt = 0;
      end else begin
        if (bus_req) begin
          if (!inAcc) begin
            inAcc = 1;
            nReq = 0;
            if (expAcc.size() == 0) begin
              haveCur = 0;
              chk("unexpected_bus_req", 32'(bus_req), 32'd0);
            end else begin
              cur = expAcc.pop_front();
              haveCur = 1;
            end
          end
          if (haveCur) begin
            chk("bus_we", 32'(bus_we), 32'(cur.we));
            chk("bus_addr", bus_addr, cur.addr);
            if (cur.we) chk("bus_wdata", bus_wdata, cur.wdata);
          end
          nReq++;
          if (bus_ack || nReq == TO) inAcc = 0;
        end
        if (inst_ren || mem_ren || mem_wen) begin
          if (stall) begin
            stallCnt++;
          end else begin
            if (expRes.size() == 0) begin
              chk("unexpected_completion", 32'(stall), 32'd1);
            end else begin
              r = expRes.pop_front();
              chk("stall_cycles", 32'(stallCnt), 32'(r.stallCyc));
              chk("mem_din", mem_din, r.mdin);
              chk("inst_data", inst_data, r.idata);
              chk("bus_err", 32'(bus_err), 32'(r.err));
            end
            stallCnt = 0;
          end
        end else begin
          chk("idle_stall", 32'(stall), 32'd0);
        end
      end
    end
  end

  task automatic summary();
    $display("test done: total=%0d bad=%0d", total, bad);
  endtask

  // One core cycle: model the expected bus accesses and results, drive the
  // requests, then hold them until stall drops. Called at posedge+2.
  task automatic doTxn(input bit ren, input bit wen, input bit iren,
                       input logic [31:0] maddr, input logic [31:0] dout,
                       input logic [31:0] iaddr, input int w0, input int w1,
                       input logic [31:0] r0, input logic [31:0] r1);
    int cyc;
    bit tmo;
    bit done;
    cyc = 1;
    if (ren || wen) begin
      expAcc.push_back('{we: wen, addr: maddr, wdata: dout});
      slvPlan.push_back('{w: w0, rdata: r0});
      tmo = (w0 >= TO);
      cyc += tmo ? TO : w0 + 1;
      if (tmo) errM = 1'b1;
      if (!wen) mdinM = tmo ? ERRV : r0;
    end
    if (iren) begin
      expAcc.push_back('{we: 1'b0, addr: iaddr, wdata: 32'h0});
      slvPlan.push_back('{w: w1, rdata: r1});
      tmo = (w1 >= TO);
      cyc += tmo ? TO : w1 + 1;
      if (tmo) errM = 1'b1;
      idataM = tmo ? ERRV : r1;
    end
    mem_ren   = ren;
    mem_wen   = wen;
    inst_ren  = iren;
    mem_addr  = maddr;
    mem_dout  = dout;
    inst_addr = iaddr;
    if (ren || wen || iren) begin
      expRes.push_back('{mdin: mdinM, idata: idataM, err: errM, stallCyc: cyc});
      done = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (!stall) begin
          done = 1;
          break;
        end
      end
      if (!done) begin
        total++;
        bad++;
        $display("FAIL txn_no_completion: stall still high after 100 cycles, required low");
        summary();
        $finish;
      end
    end else begin
      @(negedge clk);
      chk("idle_bus_req", 32'(bus_req), 32'd0);
      chk("idle_mem_din", mem_din, mdinM);
      chk("idle_inst_data", inst_data, idataM);
      chk("idle_bus_err", 32'(bus_err), 32'(errM));
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    int          d;
    bit          ren;
    bit          wen;
    bit          iren;

    // Reset state
    #1;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;

    // Fetch only, zero wait
    doTxn(0, 0, 1, 32'h0, 32'h0, 32'h40, 0, 0, 32'h0, 32'h2008_0005);
    // Load plus fetch, three waits each (ack in the TO-th cycle is normal)
    doTxn(1, 0, 1, 32'h100, 32'h0, 32'h44, 3, 3, 32'h1234_5678, 32'h8C09_0000);
    // Store then fetch
    doTxn(0, 1, 1, 32'h200, 32'hCAFE_F00D, 32'h48, 2, 0, 32'h0, 32'h0000_1111);
    // Store with both enables set is a write
    doTxn(1, 1, 0, 32'h204, 32'h5555_AAAA, 32'h0, 1, 0, 32'h7777_7777, 32'h0);
    // Idle with spurious acks
    repeat (5) doTxn(0, 0, 0, $urandom, $urandom, $urandom, 0, 0, 32'h0, 32'h0);
    // Fetch timeout, then a good access keeps the sticky error
    doTxn(0, 0, 1, 32'h0, 32'h0, 32'h4C, 99, 99, 32'h0, 32'h0);
    doTxn(1, 0, 1, 32'h108, 32'h0, 32'h50, 0, 1, 32'hA5A5_0001, 32'hA5A5_0002);
    // Data read timeout followed by a fetch
    doTxn(1, 0, 1, 32'h10C, 32'h0, 32'h54, 99, 0, 32'h0, 32'h3333_4444);

    // Random core cycles
    for (int t = 0; t < 300; t++) begin
      d    = $urandom_range(0, 3);
      ren  = (d == 1) || (d == 3);
      wen  = (d >= 2);
      iren = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 2) begin
        ren = 0;
        wen = 0;
        iren = 0;
      end
      doTxn(ren, wen, iren, $urandom, $urandom, $urandom,
            $urandom_range(0, 5), $urandom_range(0, 5), $urandom, $urandom);
    end

    // Reset in the middle of a data access
    mem_ren   = 1'b1;
    mem_wen   = 1'b0;
    mem_addr  = 32'h300;
    inst_ren  = 1'b1;
    inst_addr = 32'h58;
    expAcc.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0});
    slvPlan.push_back('{w: 99, rdata: 32'h0});
    @(posedge clk);
    #2;
    chk("pre_rst_bus_req", 32'(bus_req), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_bus_req", 32'(bus_req), 32'd0);
    chk("midrst_bus_we", 32'(bus_we), 32'd0);
    chk("midrst_bus_addr", bus_addr, 32'd0);
    chk("midrst_bus_wdata", bus_wdata, 32'd0);
    chk("midrst_inst_data", inst_data, 32'd0);
    chk("midrst_mem_din", mem_din, 32'd0);
    chk("midrst_bus_err", 32'(bus_err), 32'd0);
    chk("midrst_stall", 32'(stall), 32'd1);
    expAcc.delete();
    slvPlan.delete();
    expRes.delete();
    repeat (2) @(posedge clk);
    #2;
    mdinM  = '0;
    idataM = '0;
    errM   = 1'b0;
    rst    = 1'b1;
    doTxn(1, 0, 1, 32'h300, 32'h0, 32'h58, 1, 0, 32'h0BAD_F00D, 32'h1357_9BDF);
    repeat (3) doTxn(0, 0, 0, $urandom, $urandom, $urandom, 0, 0, 32'h0, 32'h0);

    chk("leftover_acc", 32'(expAcc.size()), 32'd0);
    chk("leftover_res", 32'(expRes.size()), 32'd0);
    summary();
    $finish;
  end

endmodule
